// File: rtl/fake_n64_controller_tx_pkg.sv
// Shared constants, state types and reply-table helpers for the fake N64 controller transmitter.
// Optional controller-pak support is enabled by defining FAKE_N64_TX_PAK_EN.
package fake_n64_pkg;

    localparam logic [7:0] CMD_INFO   = 8'h00;
    localparam logic [7:0] CMD_STATUS = 8'h01;
    localparam logic [7:0] CMD_READ   = 8'h02;
    localparam logic [7:0] CMD_WRITE  = 8'h03;
    localparam logic [7:0] CMD_RESET  = 8'hFF;

    localparam logic [5:0] NO_BYTES     = 6'd0;
    localparam logic [5:0] INFO_BYTES   = 6'd3;
    localparam logic [5:0] STATUS_BYTES = 6'd4;
    localparam logic [5:0] READ_BYTES   = 6'd33;
    localparam logic [5:0] WRITE_BYTES  = 6'd1;

    localparam int BIT_US   = 4;
    localparam int SHORT_US = 1;
    localparam int LONG_US  = 3;
    localparam int STOP_US  = 2;

`ifdef FAKE_N64_TX_PAK_EN
    localparam logic       PAK_EN     = 1'b1;
    localparam logic [7:0] PAK_STATUS = 8'h01;
`else
    localparam logic       PAK_EN     = 1'b0;
    localparam logic [7:0] PAK_STATUS = 8'h02;
`endif

    typedef enum logic [1:0] {TX_IDLE, TX_TURN, TX_BITS, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {ENC_IDLE, ENC_BIT_LOW, ENC_BIT_HIGH, ENC_STOP_LOW} enc_state_t;

    function automatic logic [5:0] reply_len(input logic [7:0] c);
        case (c)
            CMD_INFO, CMD_RESET: reply_len = INFO_BYTES;
            CMD_STATUS:          reply_len = STATUS_BYTES;
            CMD_READ:            reply_len = PAK_EN ? READ_BYTES : NO_BYTES;
            CMD_WRITE:           reply_len = PAK_EN ? WRITE_BYTES : NO_BYTES;
            default:             reply_len = NO_BYTES;
        endcase
    endfunction

    function automatic logic [7:0] reply_byte(input logic [7:0]  c,
                                              input logic [5:0]  idx,
                                              input logic [31:0] buttons,
                                              input logic [7:0]  crc,
                                              input logic [15:0] dev_id);
        case (c)
            CMD_INFO, CMD_RESET: begin
                case (idx)
                    6'd0:    reply_byte = dev_id[15:8];
                    6'd1:    reply_byte = dev_id[7:0];
                    default: reply_byte = PAK_STATUS;
                endcase
            end
            CMD_STATUS: begin
                case (idx[1:0])
                    2'd0:    reply_byte = buttons[31:24];
                    2'd1:    reply_byte = buttons[23:16];
                    2'd2:    reply_byte = buttons[15:8];
                    default: reply_byte = buttons[7:0];
                endcase
            end
            CMD_WRITE: reply_byte = crc;
            default:   reply_byte = 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/fake_n64_controller_tx_encoder.sv
// One-wire N64 symbol encoder: emits one data bit or the stop bit per start/stop request.
// done marks the final cycle of a symbol so the next symbol can follow with no gap.
module n64_bit_encoder
    import fake_n64_pkg::*;
#(
    parameter int CLKS_PER_US = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic bit_val,
    input  logic stop,
    output logic line,
    output logic done
);

    localparam int CNT_W = $clog2(LONG_US * CLKS_PER_US);
    localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
    localparam logic [CNT_W-1:0] ZERO      = CNT_W'(0);
    localparam logic [CNT_W-1:0] SHORT_M1  = CNT_W'(SHORT_US * CLKS_PER_US - 1);
    localparam logic [CNT_W-1:0] LONG_M1   = CNT_W'(LONG_US * CLKS_PER_US - 1);
    localparam logic [CNT_W-1:0] HI1_M1    = CNT_W'((BIT_US - SHORT_US) * CLKS_PER_US - 1);
    localparam logic [CNT_W-1:0] HI0_M1    = CNT_W'((BIT_US - LONG_US) * CLKS_PER_US - 1);
    localparam logic [CNT_W-1:0] STOP_M1   = CNT_W'(STOP_US * CLKS_PER_US - 1);

    enc_state_t       state_r;
    logic [CNT_W-1:0] cnt_r;
    logic             bit_r;
    logic             ready_s;

    assign done    = ((state_r == ENC_BIT_HIGH) || (state_r == ENC_STOP_LOW)) && (cnt_r == ZERO);
    assign ready_s = (state_r == ENC_IDLE) || done;

    // Phase sequencer; a new symbol launched on the final cycle keeps bit boundaries edge-exact.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ENC_IDLE;
            cnt_r   <= ZERO;
            bit_r   <= 1'b0;
            line    <= 1'b1;
        end else if (ready_s && start) begin
            state_r <= ENC_BIT_LOW;
            bit_r   <= bit_val;
            cnt_r   <= bit_val ? SHORT_M1 : LONG_M1;
            line    <= 1'b0;
        end else if (ready_s && stop) begin
            state_r <= ENC_STOP_LOW;
            cnt_r   <= STOP_M1;
            line    <= 1'b0;
        end else begin
            case (state_r)
                ENC_IDLE: begin
                    line <= 1'b1;
                end
                ENC_BIT_LOW: begin
                    if (cnt_r == ZERO) begin
                        state_r <= ENC_BIT_HIGH;
                        cnt_r   <= bit_r ? HI1_M1 : HI0_M1;
                        line    <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r - ONE;
                    end
                end
                ENC_BIT_HIGH, ENC_STOP_LOW: begin
                    if (cnt_r == ZERO) begin
                        state_r <= ENC_IDLE;
                        line    <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r - ONE;
                    end
                end
                default: begin
                    state_r <= ENC_IDLE;
                    line    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/fake_n64_controller_tx.sv
// Fake N64 controller reply transmitter: picks up the receiver handoff toggle and serialises the reply.
// Define FAKE_N64_TX_PAK_EN to answer READ/WRITE and report a controller pak as present.
module fake_n64_controller_tx
    import fake_n64_pkg::*;
#(
    parameter int          CLKS_PER_US   = 4,
    parameter int          TURNAROUND_US = 2,
    parameter logic [15:0] DEVICE_ID     = 16'h0500
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tx_handoff,
    input  logic [7:0]  cmd,
    input  logic [7:0]  crc,
    input  logic [31:0] buttons,
    output logic        data_tx,
    output logic        cur_operation
);

    localparam int TURN_CYC = TURNAROUND_US * CLKS_PER_US;
    localparam int TURN_W   = (TURN_CYC > 2) ? $clog2(TURN_CYC) : 1;
    localparam logic [TURN_W-1:0] TURN_M1 = TURN_W'(TURN_CYC - 1);

    tx_state_t         state_r;
    logic              sync1_r, sync2_r, ack_r;
    logic [1:0]        settle_r;
    logic [7:0]        cmd_r, crc_r;
    logic [31:0]       buttons_r;
    logic [5:0]        nbytes_r, byte_idx_r;
    logic [2:0]        bit_idx_r;
    logic [TURN_W-1:0] turn_cnt_r;
    logic [7:0]        cur_byte_s;
    logic              cur_bit_s, all_sent_s, detect_s, start_s, stop_s, enc_done_s;

    assign cur_byte_s = reply_byte(cmd_r, byte_idx_r, buttons_r, crc_r, DEVICE_ID);
    assign cur_bit_s  = cur_byte_s[3'd7 - bit_idx_r];
    assign all_sent_s = (byte_idx_r == nbytes_r);
    assign detect_s   = (state_r == TX_IDLE) && (settle_r == 2'd0) && (sync2_r != ack_r);

    // Symbol requests to the encoder: first bit after turnaround, then chained on each done.
    always_comb begin
        start_s = 1'b0;
        stop_s  = 1'b0;
        if ((state_r == TX_TURN) && (turn_cnt_r == TURN_W'(0))) begin
            start_s = 1'b1;
        end else if ((state_r == TX_BITS) && enc_done_s) begin
            start_s = !all_sent_s;
            stop_s  = all_sent_s;
        end else begin
            start_s = 1'b0;
            stop_s  = 1'b0;
        end
    end

    // Two-flop synchroniser for the asynchronous handoff toggle.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
        end else begin
            sync1_r <= tx_handoff;
            sync2_r <= sync1_r;
        end
    end

    // Reply FSM. After reset, ack tracks the refilling synchroniser so an old toggle is not replayed.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= TX_IDLE;
            cur_operation <= 1'b0;
            ack_r         <= 1'b0;
            settle_r      <= 2'd3;
            cmd_r         <= 8'h00;
            crc_r         <= 8'h00;
            buttons_r     <= 32'h0000_0000;
            nbytes_r      <= 6'd0;
            turn_cnt_r    <= TURN_W'(0);
        end else begin
            case (state_r)
                TX_IDLE: begin
                    if (settle_r != 2'd0) begin
                        ack_r    <= sync2_r;
                        settle_r <= settle_r - 2'd1;
                    end else if (detect_s) begin
                        ack_r      <= sync2_r;
                        cmd_r      <= cmd;
                        crc_r      <= crc;
                        buttons_r  <= buttons;
                        nbytes_r   <= reply_len(cmd);
                        turn_cnt_r <= TURN_M1;
                        if (reply_len(cmd) != NO_BYTES) begin
                            state_r       <= TX_TURN;
                            cur_operation <= 1'b1;
                        end else begin
                            state_r <= TX_IDLE;
                        end
                    end else begin
                        state_r <= TX_IDLE;
                    end
                end
                TX_TURN: begin
                    if (turn_cnt_r == TURN_W'(0)) begin
                        state_r <= TX_BITS;
                    end else begin
                        turn_cnt_r <= turn_cnt_r - TURN_W'(1);
                    end
                end
                TX_BITS: begin
                    if (stop_s) begin
                        state_r <= TX_STOP;
                    end else begin
                        state_r <= TX_BITS;
                    end
                end
                TX_STOP: begin
                    if (enc_done_s) begin
                        state_r       <= TX_IDLE;
                        cur_operation <= 1'b0;
                    end else begin
                        state_r <= TX_STOP;
                    end
                end
                default: begin
                    state_r       <= TX_IDLE;
                    cur_operation <= 1'b0;
                end
            endcase
        end
    end

    // Next-bit pointer, MSB first; the bit counter wrapping advances the byte index.
    always_ff @(posedge clk) begin
        if (reset || detect_s) begin
            byte_idx_r <= 6'd0;
            bit_idx_r  <= 3'd0;
        end else if (start_s) begin
            bit_idx_r <= bit_idx_r + 3'd1;
            if (bit_idx_r == 3'd7) begin
                byte_idx_r <= byte_idx_r + 6'd1;
            end else begin
                byte_idx_r <= byte_idx_r;
            end
        end else begin
            bit_idx_r  <= bit_idx_r;
            byte_idx_r <= byte_idx_r;
        end
    end

    n64_bit_encoder #(
        .CLKS_PER_US(CLKS_PER_US)
    ) u_encoder (
        .clk     (clk),
        .reset   (reset),
        .start   (start_s),
        .bit_val (cur_bit_s),
        .stop    (stop_s),
        .line    (data_tx),
        .done    (enc_done_s)
    );

endmodule

// File: tb/tb_fake_n64_controller_tx.sv
// Scoreboard bench for fake_n64_controller_tx: a line monitor decodes each reply and checks it
// against records queued by the stimulus. Honours FAKE_N64_TX_PAK_EN.
module tb_fake_n64_controller_tx;

    localparam int CLKS_PER_US = 4;

    logic        clk;
    logic        reset;
    logic        tx_handoff;
    logic [7:0]  cmd;
    logic [7:0]  crc;
    logic [31:0] buttons;
    logic        data_tx;
    logic        cur_operation;

    fake_n64_controller_tx #(
        .CLKS_PER_US   (CLKS_PER_US),
        .TURNAROUND_US (2),
        .DEVICE_ID     (16'h0500)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .tx_handoff    (tx_handoff),
        .cmd           (cmd),
        .crc           (crc),
        .buttons       (buttons),
        .data_tx       (data_tx),
        .cur_operation (cur_operation)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef FAKE_N64_TX_PAK_EN
    localparam logic [7:0] STATUS_EXP = 8'h01;
`else
    localparam logic [7:0] STATUS_EXP = 8'h02;
`endif

    typedef struct {
        int           nbits;
        logic [263:0] bits;
        bit           aborted;
    } rec_t;

    rec_t sb_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   mon_nbits = 0;
    bit   mon_busy = 1'b0;

    task automatic check(input string name, input logic [263:0] got, input logic [263:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    // Count consecutive samples at level lvl while a reply is in progress.
    task automatic run(input logic lvl, output int n);
        n = 0;
        while (data_tx === lvl && cur_operation === 1'b1 && n < 64) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic expect_reply(input int nbytes, input logic [263:0] bits);
        rec_t r;
        r.nbits   = nbytes * 8;
        r.bits    = bits;
        r.aborted = 1'b0;
        sb_q.push_back(r);
    endtask

    task automatic send(input logic [7:0] c, input logic [31:0] b, input logic [7:0] k);
        @(negedge clk);
        cmd        = c;
        buttons    = b;
        crc        = k;
        tx_handoff = ~tx_handoff;
    endtask

    task automatic drain(input string name, input int budget);
        int n;
        n = 0;
        while ((sb_q.size() != 0 || mon_busy) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, (n >= budget) ? 1 : 0, 0);
        sb_q.delete();
    endtask

    task automatic quiet(input string name, input int cycles);
        int act;
        act = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (data_tx !== 1'b1 || cur_operation !== 1'b0) act++;
        end
        check(name, act, 0);
    endtask

    // Monitor: decode each reply from pulse widths and score it against the queue head.
    initial begin : monitor
        int           turn, lo, hi, total, bad;
        logic [263:0] got;
        bit           aborted, done, released;
        rec_t         e;
        forever begin
            @(negedge clk);
            if (cur_operation === 1'b1) begin
                mon_busy  = 1'b1;
                mon_nbits = 0;
                got       = '0;
                bad       = 0;
                aborted   = 1'b0;
                done      = 1'b0;
                released  = 1'b0;
                run(1'b1, turn);
                total = turn;
                if (cur_operation !== 1'b1) aborted = 1'b1;
                while (!aborted && !done && mon_nbits <= 300) begin
                    run(1'b0, lo);
                    total += lo;
                    if (cur_operation !== 1'b1) begin
                        if (lo == 8) begin
                            done     = 1'b1;
                            released = (data_tx === 1'b1);
                        end else begin
                            aborted = 1'b1;
                        end
                    end else begin
                        run(1'b1, hi);
                        total += hi;
                        if (lo == 4 && hi == 12) begin
                            got = {got[262:0], 1'b1};
                        end else if (lo == 12 && hi == 4) begin
                            got = {got[262:0], 1'b0};
                        end else begin
                            got = {got[262:0], 1'b0};
                            bad++;
                        end
                        mon_nbits++;
                        if (cur_operation !== 1'b1) aborted = 1'b1;
                    end
                end
                if (sb_q.size() == 0) begin
                    check("unexpected_reply", 1, 0);
                end else begin
                    e = sb_q.pop_front();
                    check("reply_aborted", aborted, e.aborted);
                    if (!e.aborted) begin
                        check("turnaround_cycles", turn, 8);
                        check("bit_count", mon_nbits, e.nbits);
                        check("reply_bits", got, e.bits);
                        check("bad_bit_timing", bad, 0);
                        check("stop_release", released, 1);
                        check("cur_op_cycles", total, 16 + 16 * e.nbits);
                    end
                end
                mon_busy = 1'b0;
            end
        end
    end

    initial begin : stimulus
        int   n;
        rec_t r;
        reset      = 1'b1;
        tx_handoff = 1'b0;
        cmd        = 8'h00;
        crc        = 8'h00;
        buttons    = 32'h0;
        repeat (4) @(negedge clk);
        check("reset_data_tx", data_tx, 1);
        check("reset_cur_op", cur_operation, 0);
        reset = 1'b0;
        repeat (6) @(negedge clk);

        expect_reply(3, {240'h0, 8'h05, 8'h00, STATUS_EXP});
        send(8'h00, 32'h0, 8'h00);
        drain("info_drain", 1000);

        expect_reply(4, {232'h0, 32'h8001_7F80});
        send(8'h01, 32'h8001_7F80, 8'h00);
        drain("status_drain", 1000);

        expect_reply(3, {240'h0, 8'h05, 8'h00, STATUS_EXP});
        send(8'hFF, 32'h0, 8'h00);
        drain("reset_cmd_drain", 1000);

        send(8'h42, 32'hFFFF_FFFF, 8'h00);
        quiet("unknown_cmd_quiet", 200);

        expect_reply(4, {232'h0, 32'h1234_ABCD});
        send(8'h01, 32'h1234_ABCD, 8'h00);
        repeat (60) @(negedge clk);
        buttons = 32'h0;
        drain("status_latch_drain", 1000);

        r.nbits   = 24;
        r.bits    = '0;
        r.aborted = 1'b1;
        sb_q.push_back(r);
        send(8'h00, 32'h0, 8'h00);
        n = 0;
        while (!(mon_busy && mon_nbits >= 10) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("abort_wait_timeout", (n >= 1000) ? 1 : 0, 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("abort_data_tx", data_tx, 1);
        check("abort_cur_op", cur_operation, 0);
        reset = 1'b0;
        drain("abort_drain", 50);
        quiet("post_reset_quiet", 500);

`ifdef FAKE_N64_TX_PAK_EN
        expect_reply(1, {256'h0, 8'hA5});
        send(8'h03, 32'h0, 8'hA5);
        drain("write_drain", 1000);
        expect_reply(33, 264'h0);
        send(8'h02, 32'h0, 8'h00);
        drain("read_drain", 6000);
`else
        send(8'h02, 32'h0, 8'h00);
        quiet("read_nopak_quiet", 200);
        send(8'h03, 32'h0, 8'hA5);
        quiet("write_nopak_quiet", 200);
`endif

        expect_reply(3, {240'h0, 8'h05, 8'h00, STATUS_EXP});
        send(8'h00, 32'h0, 8'h00);
        drain("final_info_drain", 1000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
